// File: rtl/fp_mul_seq_if.sv
`default_nettype none
// ==========================================================================
// fp_mul_seq_if : operand/result bundle for the sequential FP multiplier
// Revision 1.0
// ==========================================================================
interface fp_mul_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic        busy;
  logic [31:0] p;
  logic        of;
  logic        uf;
  logic        nanf;
  logic        inff;
  logic        dnf;
  logic        zf;

  modport master (
    output start, a, b,
    input  done, busy, p, of, uf, nanf, inff, dnf, zf
  );

  modport slave (
    input  start, a, b,
    output done, busy, p, of, uf, nanf, inff, dnf, zf
  );
endinterface
`default_nettype wire

// File: rtl/fp_mul_seq.sv
`default_nettype none
// ==========================================================================
// fp_mul_seq : iterative IEEE-754 single multiplier, RNE, denormals flushed
// Revision 1.0
// ==========================================================================
module fp_mul_seq #(
  parameter int RADIX_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_seq_if.slave  bus
);

  localparam int         MUL_CYCLES = 24 / RADIX_BITS;
  localparam logic [4:0] CNT_LAST   = 5'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MUL    = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [31:0]        opa, opb;
  logic [47:0]        mcand, acc;
  logic [23:0]        mq, mant;
  logic [4:0]         cnt;
  logic signed [9:0]  exp_q;
  logic               g, r, s;
  logic [31:0]        p_q;
  logic               of_q, uf_q, nan_q, inf_q, dn_q, z_q;

  // Operand classification is taken straight from the held operands.
  wire [7:0]  ea = opa[30:23];
  wire [7:0]  eb = opb[30:23];
  wire        a_zero = (ea == 8'd0);
  wire        b_zero = (eb == 8'd0);
  wire        a_dn   = a_zero && (opa[22:0] != 23'd0);
  wire        b_dn   = b_zero && (opb[22:0] != 23'd0);
  wire        a_inf  = (ea == 8'hFF) && (opa[22:0] == 23'd0);
  wire        b_inf  = (eb == 8'hFF) && (opb[22:0] == 23'd0);
  wire        a_nan  = (ea == 8'hFF) && (opa[22:0] != 23'd0);
  wire        b_nan  = (eb == 8'hFF) && (opb[22:0] != 23'd0);
  wire        sign   = opa[31] ^ opb[31];

  wire [23:0] ma = a_zero ? 24'd0 : {1'b1, opa[22:0]};
  wire [23:0] mb = b_zero ? 24'd0 : {1'b1, opb[22:0]};
  wire signed [9:0] exp0 = {2'b00, ea} + {2'b00, eb} - 10'd127;

  wire [47:0] part = mcand * 48'(mq[RADIX_BITS-1:0]);

  wire        inc     = g & (r | s | mant[0]);
  wire [24:0] msum    = {1'b0, mant} + {24'd0, inc};
  wire signed [9:0] exp_r = exp_q + (msum[24] ? 10'sd1 : 10'sd0);
  wire [22:0] frac    = msum[24] ? msum[23:1] : msum[22:0];

  wire        res_nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  wire        res_inf = a_inf | b_inf;
  wire        res_zero = a_zero | b_zero;
  wire        res_ovf = (exp_r >= 10'sd255);
  wire        res_unf = (exp_r < 10'sd1);

  logic [31:0] rp;
  logic        rof, ruf, rnan, rinf, rz;

  // Result selection in fixed priority: NaN, Inf, Zero, overflow, underflow, normal.
  always_comb begin
    rp   = {sign, exp_r[7:0], frac};
    rof  = 1'b0;
    ruf  = 1'b0;
    rnan = 1'b0;
    rinf = 1'b0;
    rz   = 1'b0;
    if (res_nan) begin
      rp   = 32'h7FC0_0000;
      rnan = 1'b1;
    end else if (res_inf) begin
      rp   = {sign, 8'hFF, 23'd0};
      rinf = 1'b1;
    end else if (res_zero) begin
      rp   = {sign, 31'd0};
      rz   = 1'b1;
    end else if (res_ovf) begin
      rp   = {sign, 8'hFF, 23'd0};
      rof  = 1'b1;
      rinf = 1'b1;
    end else if (res_unf) begin
      rp   = {sign, 31'd0};
      ruf  = 1'b1;
      rz   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = UNPACK;
      UNPACK:  state_nx = MUL;
      MUL:     if (cnt == CNT_LAST) state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = bus.start ? UNPACK : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opa   <= '0;  opb  <= '0;
      mcand <= '0;  acc  <= '0;
      mq    <= '0;  mant <= '0;
      cnt   <= '0;  exp_q <= '0;
      g     <= 1'b0; r <= 1'b0; s <= 1'b0;
      p_q   <= '0;
      of_q  <= 1'b0; uf_q <= 1'b0; nan_q <= 1'b0;
      inf_q <= 1'b0; dn_q <= 1'b0; z_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            opa <= bus.a;
            opb <= bus.b;
          end
        end
        UNPACK: begin
          mcand <= {24'd0, ma};
          mq    <= mb;
          acc   <= '0;
          cnt   <= '0;
          exp_q <= exp0;
        end
        MUL: begin
          acc   <= acc + part;
          mcand <= mcand << RADIX_BITS;
          mq    <= mq >> RADIX_BITS;
          cnt   <= cnt + 5'd1;
        end
        NORM: begin
          if (acc[47]) begin
            mant  <= acc[47:24];
            g     <= acc[23];
            r     <= acc[22];
            s     <= |acc[21:0];
            exp_q <= exp_q + 10'sd1;
          end else begin
            mant  <= acc[46:23];
            g     <= acc[22];
            r     <= acc[21];
            s     <= |acc[20:0];
          end
        end
        ROUND: begin
          p_q   <= rp;
          of_q  <= rof;
          uf_q  <= ruf;
          nan_q <= rnan;
          inf_q <= rinf;
          dn_q  <= a_dn | b_dn;
          z_q   <= rz;
        end
        default: ;
      endcase
    end
  end

  assign bus.done = (state == DONE);
  assign bus.busy = (state != IDLE);
  assign bus.p    = p_q;
  assign bus.of   = of_q;
  assign bus.uf   = uf_q;
  assign bus.nanf = nan_q;
  assign bus.inff = inf_q;
  assign bus.dnf  = dn_q;
  assign bus.zf   = z_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
`default_nettype none
// ==========================================================================
// tb_fp_mul_seq : directed vector table plus multi-cycle corner sequences
// Revision 1.0
// ==========================================================================
module tb_fp_mul_seq;

  localparam int LAT = 27;

  localparam logic [5:0] F_OF  = 6'b100000;
  localparam logic [5:0] F_UF  = 6'b010000;
  localparam logic [5:0] F_NAN = 6'b001000;
  localparam logic [5:0] F_INF = 6'b000100;
  localparam logic [5:0] F_DN  = 6'b000010;
  localparam logic [5:0] F_Z   = 6'b000001;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [5:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fp_mul_seq_if bus ();

  fp_mul_seq #(.RADIX_BITS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {bus.of, bus.uf, bus.nanf, bus.inff, bus.dnf, bus.zf};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                        output logic [31:0] rp, output logic [5:0] rf,
                        output int lat, output int bcyc);
    rp = '0; rf = '0; lat = -1;
    @(negedge clk);
    bus.a = ta; bus.b = tb; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bcyc = bus.busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.busy) bcyc++;
      if (bus.done && lat < 0) begin
        lat = k;
        rp  = bus.p;
        rf  = flags();
      end
      if (lat >= 0 && !bus.busy) break;
    end
  endtask

  vec_t        vecs[20];
  logic [31:0] rp;
  logic [5:0]  rf;
  int          lat, bcyc, ndone, lat2;

  initial begin
    vecs[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 6'b0};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 6'b0};
    vecs[2]  = '{32'h3FC00000, 32'h80000000, 32'h80000000, F_Z};
    vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, F_OF | F_INF};
    vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, F_UF | F_Z};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, F_NAN};
    vecs[6]  = '{32'h00000001, 32'h3F800000, 32'h00000000, F_DN | F_Z};
    vecs[7]  = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 6'b0};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, F_NAN};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, F_INF};
    vecs[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 6'b0};
    vecs[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 6'b0};
    vecs[12] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 6'b0};
    vecs[13] = '{32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, F_OF | F_INF};
    vecs[14] = '{32'h00800000, 32'h3F800000, 32'h00800000, 6'b0};
    vecs[15] = '{32'h00800000, 32'h3F000000, 32'h00000000, F_UF | F_Z};
    vecs[16] = '{32'h80000000, 32'h80000000, 32'h00000000, F_Z};
    vecs[17] = '{32'h7F800000, 32'h00000001, 32'h7FC00000, F_NAN | F_DN};
    vecs[18] = '{32'hFF800000, 32'h7F800000, 32'hFF800000, F_INF};
    vecs[19] = '{32'h00000001, 32'h7FC00000, 32'h7FC00000, F_NAN | F_DN};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_p",     bus.p,         32'd0);
    chk("rst_flags", 32'(flags()),  32'd0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].a, vecs[i].b, rp, rf, lat, bcyc);
      chk($sformatf("vec%0d_p", i),     rp,          vecs[i].p);
      chk($sformatf("vec%0d_flags", i), 32'(rf),     32'(vecs[i].f));
      chk($sformatf("vec%0d_lat", i),   32'(lat),    32'(LAT));
      if (i == 0) chk("vec0_busy_cycles", 32'(bcyc), 32'd28);
    end

    // start re-asserted mid-operation must not disturb the op in flight
    @(negedge clk);
    bus.a = 32'h40400000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.start = 1'b1;
      end
      if (k == 11) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          chk("busy_start_lat", 32'(k), 32'(LAT));
          chk("busy_start_p",   bus.p,  32'h40C00000);
        end
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);

    // start held in DONE chains a second operation
    @(negedge clk);
    bus.a = 32'h40400000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    chk("b2b_lat1", 32'(lat), 32'(LAT));
    bus.a = 32'hC0000000; bus.b = 32'h40400000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    lat2 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 5) chk("b2b_p_hold", bus.p, 32'h40C00000);
      if (bus.done) begin lat2 = k; break; end
    end
    chk("b2b_lat2", 32'(lat2), 32'(LAT));
    chk("b2b_p",    bus.p,     32'hC0C00000);

    // reset in the middle of an operation
    @(negedge clk);
    @(posedge clk); #1;
    bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_done",  32'(bus.done), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy), 32'd0);
    chk("mid_rst_p",     bus.p,         32'd0);
    chk("mid_rst_flags", 32'(flags()),  32'd0);
    rst = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    run_op(32'h3F800000, 32'h40000000, rp, rf, lat, bcyc);
    chk("post_rst_p",   rp,       32'h40000000);
    chk("post_rst_lat", 32'(lat), 32'(LAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
